// File: rtl/stack_ctrl.sv
// Stack access controller: turns PUSH/POP/PEEK/CLEAR requests into single
// memory transactions, with SP bounds checking, ack timeout and SP update strobe.
module stack_ctrl #(
    parameter int SP_INIT  = 62,
    parameter int SP_LIMIT = 32,
    parameter int TMO      = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [15:0] op_data,
    output logic        op_ready,
    input  logic [15:0] sp_in,
    output logic        change_sp,
    output logic [15:0] next_sp,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        done,
    output logic [1:0]  err,
    output logic [15:0] rd_data
);

    typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_PEEK  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_OVF = 2'b01;
    localparam logic [1:0] ERR_UNF = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
    localparam logic [15:0]   SP_EMPTY = 16'(SP_INIT);
    localparam logic [15:0]   SP_LOW   = 16'(SP_LIMIT);

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [15:0]   data_q, data_d;
    logic [15:0]   sp_q, sp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic          change_sp_q, change_sp_d;
    logic [15:0]   next_sp_q, next_sp_d;
    logic [15:0]   rd_data_q, rd_data_d;

    // State register; the async reset drops mem_req at once because it is
    // decoded straight from state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_PUSH;
            data_q      <= '0;
            sp_q        <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= ERR_OK;
            change_sp_q <= 1'b0;
            next_sp_q   <= SP_EMPTY;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            sp_q        <= sp_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            change_sp_q <= change_sp_d;
            next_sp_q   <= next_sp_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        sp_d        = sp_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = err_q;
        change_sp_d = 1'b0;
        next_sp_d   = next_sp_q;
        rd_data_d   = rd_data_q;

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    op_d   = op;
                    data_d = op_data;
                    sp_d   = sp_in;
                    cnt_d  = '0;
                    case (op)
                        OP_PUSH: begin
                            if (sp_in >= SP_LOW) begin
                                state_d = WR;
                            end else begin
                                state_d = FIN;
                                done_d  = 1'b1;
                                err_d   = ERR_OVF;
                            end
                        end
                        OP_POP, OP_PEEK: begin
                            if (sp_in < SP_EMPTY) begin
                                state_d = RD;
                            end else begin
                                state_d = FIN;
                                done_d  = 1'b1;
                                err_d   = ERR_UNF;
                            end
                        end
                        default: begin
                            state_d     = FIN;
                            done_d      = 1'b1;
                            err_d       = ERR_OK;
                            change_sp_d = 1'b1;
                            next_sp_d   = SP_EMPTY;
                        end
                    endcase
                end
            end
            WR: begin
                if (mem_ack) begin
                    state_d     = FIN;
                    done_d      = 1'b1;
                    err_d       = ERR_OK;
                    change_sp_d = 1'b1;
                    next_sp_d   = sp_q - 16'd1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    err_d   = ERR_TMO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD: begin
                if (mem_ack) begin
                    state_d   = FIN;
                    done_d    = 1'b1;
                    err_d     = ERR_OK;
                    rd_data_d = mem_rdata;
                    if (op_q == OP_POP) begin
                        change_sp_d = 1'b1;
                        next_sp_d   = sp_q + 16'd1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    err_d   = ERR_TMO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state and latched request; stable while mem_req is up
    always_comb begin
        op_ready  = (state_q == IDLE);
        mem_req   = (state_q == WR) || (state_q == RD);
        mem_we    = (state_q == WR);
        mem_addr  = (op_q == OP_PUSH) ? sp_q : (sp_q + 16'd1);
        mem_wdata = data_q;
    end

    assign done      = done_q;
    assign err       = err_q;
    assign change_sp = change_sp_q;
    assign next_sp   = next_sp_q;
    assign rd_data   = rd_data_q;

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- SP_INIT, 62: empty-stack SP value.
- SP_LIMIT, 32: lowest writable stack address.
- TMO, 15: memory-ack timeout in cycles.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: reset; asynchronous, active-high.
- op_valid, in, 1: operation request.
- op, in, 2: 00 PUSH, 01 POP, 10 PEEK, 11 CLEAR.
- op_data, in, 16: PUSH data.
- op_ready, out, 1: request accepted when op_valid and op_ready are both 1.
- sp_in, in, 16: current SP from the SP register.
- change_sp, out, 1: SP write strobe to the SP register.
- next_sp, out, 16: new SP value, valid while change_sp is 1.
- mem_req, out, 1: memory access request.
- mem_we, out, 1: 1 = write.
- mem_addr, out, 16: memory address.
- mem_wdata, out, 16: write data.
- mem_ack, in, 1: memory completion.
- mem_rdata, in, 16: read data, valid with mem_ack.
- done, out, 1: one-cycle completion pulse.
- err, out, 2: 00 ok, 01 overflow, 10 underflow, 11 timeout; valid with done.
- rd_data, out, 16: POP/PEEK result.

Function
REQ-003 The FSM SHALL have states IDLE, WR, RD and FIN; op_ready SHALL be 1 only in IDLE.
REQ-004 On acceptance, op, op_data and sp_in SHALL be latched; later changes to these inputs SHALL have no effect.
REQ-005 PUSH SHALL be legal when latched SP >= SP_LIMIT: go to WR with mem_addr=SP, mem_wdata=op_data, mem_we=1; otherwise go to FIN with err=01 and no memory access.
REQ-006 POP SHALL be legal when SP < SP_INIT: go to RD with mem_addr=SP+1, mem_we=0; otherwise go to FIN with err=10.
REQ-007 PEEK SHALL follow the POP rules (same address, same underflow check) but SHALL never assert change_sp.
REQ-008 CLEAR SHALL go directly to FIN with no memory access.
REQ-009 mem_req SHALL be 1 throughout WR and RD and 0 in all other states; mem_addr, mem_we and mem_wdata SHALL be stable while mem_req is 1.
REQ-010 In WR or RD, a sampled mem_ack SHALL move the state to FIN; in RD, mem_rdata SHALL be captured into rd_data on that edge.
REQ-011 mem_ack sampled outside WR and RD SHALL be ignored.
REQ-012 A wait counter SHALL clear on entry to WR or RD and increment each cycle without ack.
- When the count reaches TMO without ack, the block SHALL go to FIN with err=11, SP unchanged and rd_data unchanged.
REQ-013 FIN SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-014 change_sp SHALL be 1 only in FIN, when err=00 and op is PUSH, POP or CLEAR.
- next_sp SHALL be SP-1 for PUSH, SP+1 for POP, SP_INIT for CLEAR.
- SP arithmetic SHALL be 16-bit modulo.
REQ-015 Latency with a zero-wait memory (ack in the first WR/RD cycle):
- Acceptance on edge k; done high in cycle k+2.
- CLEAR and error cases: done high in cycle k+1.
REQ-016 rd_data SHALL hold its value until the next successful POP or PEEK.
REQ-017 done, change_sp and err SHALL be registered outputs.

Reset
REQ-018 On reset:
- state = IDLE; mem_req, mem_we, change_sp and done = 0.
- err = 00; rd_data = 0; next_sp = SP_INIT; wait counter = 0.
REQ-019 When reset is asserted mid-WR or mid-RD, mem_req SHALL drop immediately (asynchronously), no change_sp SHALL issue, and a late mem_ack after reset SHALL be ignored.

Verification
REQ-020 PUSH 0xABCD at sp_in=62, ack on first cycle -> mem_addr=62, mem_wdata=0xABCD, mem_we=1; done 2 cycles after accept; change_sp=1, next_sp=61, err=00.
REQ-021 POP at sp_in=61, ack with mem_rdata=0xABCD -> mem_addr=62, mem_we=0; rd_data=0xABCD, next_sp=62, err=00.
REQ-022 POP or PEEK at sp_in=62 -> done 1 cycle after accept, err=10, mem_req never asserted, change_sp=0; PUSH at sp_in=31 -> err=01, mem_req never asserted.
REQ-023 PUSH at sp_in=40 with mem_ack held 0 -> mem_req high for 15 cycles, then done with err=11, change_sp=0.
REQ-024 PEEK at sp_in=50, ack with mem_rdata=0x1234 -> rd_data=0x1234, change_sp=0; then CLEAR -> next_sp=62, done 1 cycle after accept.
REQ-025 Assert reset 2 cycles into WR, then pulse mem_ack after release -> mem_req=0 immediately, state IDLE, no done, no change_sp.
